// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: multi-cycle accumulator CPU controller driving a 32x8 registered-read RAM
module fetch_exec_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Mem_Data_Out,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_WE,
  output logic [DATA_W-1:0] Mem_Data_In,
  output logic              Mem_Init,
  output logic [DATA_W-1:0] Acc_Out,
  output logic [ADDR_W-1:0] PC_Out,
  output logic              Halted
);
  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEMRD  = 3'd4;
  localparam logic [2:0] S_INWAIT = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_IN    = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_JNC   = 3'd6;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [2:0]        op;
  logic [ADDR_W-1:0] m;
  logic [DATA_W:0]   alu;
  logic              mem_op;
  assign op  = ir_q[DATA_W-1 -: 3];
  assign m   = ir_q[ADDR_W-1:0];
  // Extra top bit is carry-out for ADD and borrow (A<M) for SUB
  assign alu = (op == OP_SUB) ? {1'b0, acc_q} - {1'b0, Mem_Data_Out}
                              : {1'b0, acc_q} + {1'b0, Mem_Data_Out};
  assign mem_op      = (state_q == S_EXEC) && (op == OP_LOAD || op == OP_STORE || op == OP_ADD || op == OP_SUB);
  assign Mem_Addr    = (state_q == S_FETCH) ? pc_q : mem_op ? m : '0;
  assign Mem_WE      = (state_q == S_EXEC) && (op == OP_STORE);
  assign Mem_Init    = (state_q == S_INIT) && !Reset;
  assign Mem_Data_In = acc_q;
  assign Acc_Out     = acc_q;
  assign PC_Out      = pc_q;
  assign Halted      = (state_q == S_HALT);
  assign In_Ready    = (state_q == S_INWAIT);
  // Next-state and datapath updates for the fetch/decode/execute sequence
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    c_d     = c_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = Mem_Data_Out;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = (op == OP_LOAD || op == OP_ADD || op == OP_SUB) ? S_MEMRD :
                  (op == OP_IN) ? S_INWAIT : (op == 3'd7) ? S_HALT : S_FETCH;
        pc_d    = ((op == OP_JZ && acc_q == '0) || (op == OP_JNC && !c_q)) ? m : pc_q;
      end
      S_MEMRD: begin
        acc_d   = (op == OP_LOAD) ? Mem_Data_Out : alu[DATA_W-1:0];
        c_d     = (op == OP_LOAD) ? c_q : alu[DATA_W];
        state_d = S_FETCH;
      end
      S_INWAIT: begin
        acc_d   = In_Valid ? In_Data : acc_q;
        state_d = In_Valid ? S_FETCH : S_INWAIT;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end
  // State and architectural registers, cleared asynchronously by Reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
    end
  end
endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// tb_fetch_exec_ctrl: directed scoreboard bench with a behavioural 32x8 RAM
module tb_fetch_exec_ctrl;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] In_Data = '0;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic [7:0] Mem_Data_Out;
  logic [4:0] Mem_Addr;
  logic       Mem_WE;
  logic [7:0] Mem_Data_In;
  logic       Mem_Init;
  logic [7:0] Acc_Out;
  logic [4:0] PC_Out;
  logic       Halted;
  logic [7:0] ram [32];
  logic [7:0] prog [32];
  logic [7:0] exp_q [$];
  logic [7:0] acc_prev = '0;
  logic [7:0] e;
  logic       mon_en = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         f7 = 0;

  fetch_exec_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Mem_Data_Out(Mem_Data_Out), .Mem_Addr(Mem_Addr), .Mem_WE(Mem_WE), .Mem_Data_In(Mem_Data_In),
    .Mem_Init(Mem_Init), .Acc_Out(Acc_Out), .PC_Out(PC_Out), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Mem_Init) for (int i = 0; i < 32; i++) ram[i] <= prog[i];
    else if (Mem_WE) ram[Mem_Addr] <= Mem_Data_In;
    Mem_Data_Out <= ram[Mem_Addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (mon_en && !Reset && Acc_Out !== acc_prev) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ~Acc_Out;
      check("acc_seq", Acc_Out, e);
      acc_prev = Acc_Out;
    end
    if (mon_en && !Reset && Mem_Addr == 5'd7) f7++;
  end

  task automatic set_prog(input int t);
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    if (t == 0) begin
      prog[0] = 8'h80; prog[1] = 8'h3E; prog[2] = 8'h80; prog[3] = 8'h3F;
      prog[4] = 8'h1E; prog[5] = 8'h7F; prog[6] = 8'hAE; prog[7] = 8'hCC;
      prog[8] = 8'h1F; prog[9] = 8'h7E; prog[10] = 8'h3F; prog[11] = 8'hC4;
      prog[12] = 8'h3E; prog[13] = 8'hC4; prog[14] = 8'h1E; prog[15] = 8'h3F;
      prog[16] = 8'h1F; prog[17] = 8'hE0;
    end else begin
      prog[0] = 8'h80; prog[1] = 8'h14; prog[2] = 8'h55; prog[3] = 8'hC9;
      prog[4] = 8'h16; prog[5] = 8'h77; prog[6] = 8'hC9; prog[7] = 8'h38;
      prog[8] = 8'hE0; prog[9] = 8'h19; prog[10] = 8'hE0;
      prog[20] = 8'hF0; prog[21] = 8'h20; prog[22] = 8'h05; prog[23] = 8'h06; prog[25] = 8'h42;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    In_Valid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("rst_acc", Acc_Out, 0);
    check("rst_pc", PC_Out, 0);
    check("rst_halt", Halted, 0);
    check("rst_rdy", In_Ready, 0);
    check("rst_we", Mem_WE, 0);
    check("rst_init", Mem_Init, 0);
    check("rst_addr", Mem_Addr, 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("init_strobe", Mem_Init, 1);
    check("init_addr", Mem_Addr, 0);
    exp_q.delete();
    acc_prev = '0;
    f7 = 0;
    mon_en = 1'b1;
    @(negedge Clock);
    check("fetch_init", Mem_Init, 0);
    check("fetch_addr", Mem_Addr, 0);
    check("fetch_we", Mem_WE, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && In_Ready !== 1'b1; i++) @(negedge Clock);
    check("ready_seen", In_Ready, 1);
  endtask

  task automatic feed_in(input logic [7:0] d);
    wait_ready();
    In_Data = d;
    In_Valid = 1'b1;
    @(posedge Clock);
    #1;
    In_Valid = 1'b0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 2000 && Halted !== 1'b1; i++) @(negedge Clock);
    check("halted", Halted, 1);
  endtask

  initial begin
    set_prog(0);
    do_reset();
    exp_q = '{8'd12, 8'd18, 8'd12, 8'd250, 8'd18, 8'd6, 8'd12, 8'd6, 8'd0, 8'd6};
    feed_in(8'd12);
    feed_in(8'd18);
    wait_halt();
    check("gcd_acc", Acc_Out, 6);
    check("gcd_pc", PC_Out, 18);
    check("gcd_ram30", ram[30], 6);
    check("gcd_ram31", ram[31], 6);
    check("gcd_q_left", exp_q.size(), 0);
    repeat (3) @(negedge Clock);
    check("halt_sticky", Halted, 1);
    check("halt_we", Mem_WE, 0);

    do_reset();
    exp_q = '{8'd7, 8'd0, 8'd7};
    feed_in(8'd7);
    feed_in(8'd7);
    wait_halt();
    check("eq_acc", Acc_Out, 7);
    check("eq_pc", PC_Out, 18);
    check("eq_jz_taken", f7, 0);
    check("eq_q_left", exp_q.size(), 0);

    set_prog(1);
    do_reset();
    exp_q = '{8'hA5, 8'hF0, 8'h10, 8'h05, 8'hFF};
    wait_ready();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("stall_rdy", In_Ready, 1);
      check("stall_acc", Acc_Out, 0);
    end
    In_Data = 8'hA5;
    In_Valid = 1'b1;
    @(posedge Clock);
    #1;
    check("in_acc", Acc_Out, 8'hA5);
    check("in_rdy", In_Ready, 0);
    In_Data = 8'h33;
    wait_halt();
    In_Valid = 1'b0;
    check("alu_acc", Acc_Out, 8'hFF);
    check("alu_pc", PC_Out, 9);
    check("alu_store", ram[24], 8'hFF);
    check("alu_q_left", exp_q.size(), 0);

    do_reset();
    mon_en = 1'b0;
    feed_in(8'hA5);
    for (int i = 0; i < 200 && Mem_WE !== 1'b1; i++) @(negedge Clock);
    check("store_seen", Mem_WE, 1);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_we", Mem_WE, 0);
    check("abort_addr", Mem_Addr, 0);
    check("abort_acc", Acc_Out, 0);
    check("abort_pc", PC_Out, 0);
    repeat (2) @(negedge Clock);
    check("abort_ram24", ram[24], 8'h00);
    Reset = 1'b0;
    #1;
    check("abort_restart", Mem_Init, 1);
    @(negedge Clock);
    check("abort_fetch", Mem_Addr, 0);
    check("abort_ram24_post", ram[24], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_exec_ctrl.md
FETCH_EXEC_CTRL -- requirements
Module: fetch_exec_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width (32 words).
REQ-002 Parameter DATA_W, default 8, data/instruction width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Clock  input  1  rising-edge clock, shared with the 32x8 program/data RAM.
REQ-005 Reset  input  1  asynchronous active-high reset.
REQ-006 In_Data  input  8  external operand for IN instruction.
REQ-007 In_Valid  input  1  In_Data valid.
REQ-008 In_Ready  output  1  block is waiting in IN; transfer occurs when In_Valid&&In_Ready at a clock edge.
REQ-009 Mem_Data_Out  input  8  RAM registered read data (valid the cycle after address presented with Mem_WE=0).
REQ-010 Mem_Addr  output  5  RAM address.
REQ-011 Mem_WE  output  1  RAM write enable.
REQ-012 Mem_Data_In  output  8  RAM write data (always = accumulator A).
REQ-013 Mem_Init  output  1  RAM preload strobe.
REQ-014 Acc_Out  output  8  accumulator A; PC_Out  output  5  program counter; Halted  output  1  HALT reached.

Function
REQ-015 Instruction = IR[7:5] opcode, IR[4:0] operand address M.
REQ-016 Opcodes SHALL be: 000 LOAD A<=M; 001 STORE M<=A; 010 ADD A<=A+M; 011 SUB A<=A-M; 100 IN A<=In_Data; 101 JZ (PC<=addr if A==0); 110 JNC (PC<=addr if C==0); 111 HALT.
REQ-017 Arithmetic SHALL be modulo 256; ADD sets C=carry-out of bit 7; SUB sets C=1 iff A<M (borrow); C unchanged by all other opcodes.
REQ-018 States SHALL be INIT, FETCH, DECODE, EXEC, MEMRD, INWAIT, HALT.
REQ-019 INIT: Mem_Init=1 for exactly one cycle, then FETCH.
REQ-020 FETCH: Mem_Addr=PC, Mem_WE=0; next DECODE.
REQ-021 DECODE: IR<=Mem_Data_Out, PC<=PC+1 (31 wraps to 0); next EXEC.
REQ-022 EXEC LOAD/ADD/SUB: Mem_Addr=IR[4:0], Mem_WE=0; next MEMRD; MEMRD updates A (and C) from Mem_Data_Out, next FETCH.
REQ-023 EXEC STORE: Mem_Addr=IR[4:0], Mem_WE=1, Mem_Data_In=A for exactly one cycle; next FETCH.
REQ-024 EXEC JZ/JNC: condition evaluated on current A/C; taken -> PC<=IR[4:0], else PC unchanged; next FETCH.
REQ-025 EXEC IN: next INWAIT; INWAIT drives In_Ready=1; on In_Valid=1, A<=In_Data, next FETCH; else remain (no timeout); In_Valid outside INWAIT ignored.
REQ-026 EXEC HALT: next HALT; HALT is terminal until Reset, Halted=1, Mem_WE=0.
REQ-027 Cycle counts: LOAD/ADD/SUB 4; STORE/JZ/JNC 3; IN 3+wait cycles.
REQ-028 Mem_WE SHALL be 1 only in EXEC of STORE; Mem_Init only in INIT; all memory outputs are Moore (decoded from state and registers), glitch-free at the clock edge.
REQ-029 Jump target equal to current PC (self-loop) SHALL be legal and loop indefinitely.

Reset
REQ-030 Reset=1 SHALL immediately force state=INIT, PC=0, A=0, C=0, IR=0, Halted=0, In_Ready=0, Mem_WE=0, Mem_Init=0, Mem_Addr=0, independent of Clock.
REQ-031 Reset mid-instruction (including mid-STORE or INWAIT) SHALL abort it with no write; first edge after release executes INIT.

Verification
REQ-032 Reset release -> Mem_Init=1 for one cycle, then FETCH at PC=0, Mem_Addr=0.
REQ-033 Preloaded program, In_Data 12 then 18 -> Halted=1, Acc_Out=6 (GCD), RAM[30]=RAM[31]=6, PC_Out=18.
REQ-034 Inputs 7 and 7 -> JZ taken at addr 6, Halted=1, Acc_Out=7.
REQ-035 IN with In_Valid held low 10 cycles -> In_Ready=1 throughout, A unchanged; In_Valid=1 with 0xA5 -> A=0xA5 next edge, In_Ready=0.
REQ-036 ADD 0xF0+0x20 -> A=0x10, C=1; SUB 0x05-0x06 -> A=0xFF, C=1; next JNC not taken.
REQ-037 Reset asserted during STORE EXEC cycle -> Mem_WE drops immediately, target word unchanged, restart at INIT.
